// File: rtl/fm_phase_gen_if.sv
// Sample-side and CORDIC-side signal bundle for fm_phase_gen.
// master drives audio/strobe/config, slave (the generator) drives the CORDIC inputs.
interface fm_phase_gen_if #(
  parameter int WIDTH  = 16,
  parameter int ZWIDTH = 24,
  parameter int AWIDTH = 16,
  parameter int GWIDTH = 16
);
  logic signed [AWIDTH-1:0] audio;
  logic                     stb_in;
  logic [ZWIDTH-1:0]        carrier_fw;
  logic [GWIDTH-1:0]        dev_gain;
  logic                     phase_clr;
  logic signed [WIDTH-1:0]  xo;
  logic signed [WIDTH-1:0]  yo;
  logic [ZWIDTH-1:0]        zo;
  logic                     stb_out;

  modport master (
    output audio, stb_in, carrier_fw, dev_gain, phase_clr,
    input  xo, yo, zo, stb_out
  );

  modport slave (
    input  audio, stb_in, carrier_fw, dev_gain, phase_clr,
    output xo, yo, zo, stb_out
  );
endinterface

// File: rtl/fm_phase_gen.sv
// FM phase generator feeding a rotation-mode CORDIC: 4-stage pipeline of
// deviation multiply, frequency sum, phase accumulate and +/-90 deg fold.
// Optional macro PHASE_DITHER_EN adds LFSR dither to the folded angle only.
module fm_phase_gen #(
  parameter int WIDTH     = 16,
  parameter int ZWIDTH    = 24,
  parameter int AWIDTH    = 16,
  parameter int GWIDTH    = 16,
  parameter int DEV_SHIFT = 8,
  parameter int AMPLITUDE = 19897
) (
  input logic           clk,
  input logic           rst,
  fm_phase_gen_if.slave bus
);
  localparam int PWIDTH = AWIDTH + GWIDTH + 1;
  localparam logic signed [WIDTH-1:0] AMP_POS = WIDTH'(AMPLITUDE);
  localparam logic signed [WIDTH-1:0] AMP_NEG = -AMP_POS;

  logic                     v1, v2, v3, v4;
  logic signed [PWIDTH-1:0] prod_r;
  logic signed [PWIDTH-1:0] prod_shift;
  logic [ZWIDTH-1:0]        dev_z;
  logic [ZWIDTH-1:0]        freq_r;
  logic [ZWIDTH-1:0]        phase_r;
  logic [ZWIDTH-1:0]        fold_in;
  logic [ZWIDTH-1:0]        zo_next;
  logic signed [WIDTH-1:0]  xo_next;
  logic [1:0]               quad;
  logic                     flip;
  logic [ZWIDTH-1:0]        zo_r;
  logic signed [WIDTH-1:0]  xo_r;
  logic [PWIDTH-1:0]        unused_shift_bits;

  // Sized cast both truncates and sign-extends, so any PWIDTH/ZWIDTH mix works.
  assign prod_shift        = prod_r >>> DEV_SHIFT;
  assign dev_z             = ZWIDTH'(prod_shift);
  assign unused_shift_bits = prod_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      prod_r <= '0;
      freq_r <= '0;
    end else begin
      v1     <= bus.stb_in;
      v2     <= v1;
      v3     <= v2;
      v4     <= v3;
      prod_r <= $signed({{(GWIDTH+1){bus.audio[AWIDTH-1]}}, bus.audio})
              * $signed({{(AWIDTH+1){1'b0}}, bus.dev_gain});
      freq_r <= bus.carrier_fw + dev_z;
    end
  end

  // Clear wins over a coinciding accumulate; that sample's valid still flows on.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= '0;
    end else if (bus.phase_clr) begin
      phase_r <= '0;
    end else if (v2) begin
      phase_r <= phase_r + freq_r;
    end
  end

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 16'hACE1;
    end else if (v3) begin
      lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    end
  end

  assign fold_in = phase_r + ZWIDTH'(lfsr_r[3:0]);
`else
  assign fold_in = phase_r;
`endif

  // Quadrants 01/10 are rotated by pi so the angle lands inside +/-90 deg.
  always_comb begin
    quad    = fold_in[ZWIDTH-1:ZWIDTH-2];
    flip    = quad[1] ^ quad[0];
    zo_next = {fold_in[ZWIDTH-1] ^ flip, fold_in[ZWIDTH-2:0]};
    xo_next = flip ? AMP_NEG : AMP_POS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zo_r <= '0;
      xo_r <= '0;
    end else if (v3) begin
      zo_r <= zo_next;
      xo_r <= xo_next;
    end
  end

  assign bus.zo      = zo_r;
  assign bus.xo      = xo_r;
  assign bus.yo      = '0;
  assign bus.stb_out = v4;
endmodule

// File: tb/tb_fm_phase_gen.sv
// Scoreboard bench for fm_phase_gen: a sample-level reference model pushes the
// expected CORDIC inputs per strobe; a negedge monitor pops and compares them.
module tb_fm_phase_gen;
  localparam int WIDTH     = 16;
  localparam int ZWIDTH    = 24;
  localparam int AWIDTH    = 16;
  localparam int GWIDTH    = 16;
  localparam int DEV_SHIFT = 8;
  localparam int AMPLITUDE = 19897;

  typedef struct {
    logic [23:0] zo;
    logic [15:0] xo;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fm_phase_gen_if #(.WIDTH(WIDTH), .ZWIDTH(ZWIDTH), .AWIDTH(AWIDTH), .GWIDTH(GWIDTH)) bus ();

  fm_phase_gen #(
    .WIDTH(WIDTH), .ZWIDTH(ZWIDTH), .AWIDTH(AWIDTH), .GWIDTH(GWIDTH),
    .DEV_SHIFT(DEV_SHIFT), .AMPLITUDE(AMPLITUDE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_in = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  bit          clr_d1 = 1'b0;
  bit          clr_d2 = 1'b0;
  logic [23:0] mphase = '0;
  logic [15:0] mlfsr = 16'hACE1;
  exp_t        sb[$];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stb_out === 1'b1) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stb_out_unexpected at cycle %0d: got stb_out=1, expected no output", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (cyc !== mon_e.due) begin
            errors++;
            $display("FAIL latency: stb_out at cycle %0d, expected cycle %0d", cyc, mon_e.due);
          end
          checks++;
          if (bus.zo !== mon_e.zo) begin
            errors++;
            $display("FAIL zo at cycle %0d: got %06h expected %06h", cyc, bus.zo, mon_e.zo);
          end
          checks++;
          if (bus.xo !== mon_e.xo) begin
            errors++;
            $display("FAIL xo at cycle %0d: got %0d expected %0d", cyc, bus.xo, $signed(mon_e.xo));
          end
          checks++;
          if (bus.yo !== 16'h0000) begin
            errors++;
            $display("FAIL yo at cycle %0d: got %04h expected 0000", cyc, bus.yo);
          end
        end
      end else if (bus.stb_out !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL stb_out_unknown at cycle %0d: got %b expected 0", cyc, bus.stb_out);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic push_sample(input logic [15:0] a, input bit c);
    longint      p;
    logic [23:0] dev;
    logic [23:0] freq;
    logic [23:0] d;
    logic [1:0]  q;
    exp_t        e;
    p    = longint'($signed(a)) * longint'(bus.dev_gain);
    p    = p >>> DEV_SHIFT;
    dev  = p[23:0];
    freq = bus.carrier_fw + dev;
    mphase = c ? 24'h000000 : mphase + freq;
    d = mphase;
`ifdef PHASE_DITHER_EN
    d = mphase + {20'h0, mlfsr[3:0]};
    mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
`endif
    q = d[23:22];
    if (q == 2'b01 || q == 2'b10) begin
      e.zo = d ^ 24'h800000;
      e.xo = 16'(-AMPLITUDE);
    end else begin
      e.zo = d;
      e.xo = 16'(AMPLITUDE);
    end
    e.due = cyc + 4;
    sb.push_back(e);
    n_in++;
  endtask

  // c=1 asserts phase_clr exactly when this sample reaches the accumulator.
  task automatic step(input bit s, input logic [15:0] a, input bit c);
    bus.stb_in    = s;
    bus.audio     = a;
    bus.phase_clr = clr_d2;
    if (s && !rst) push_sample(a, c);
    @(posedge clk);
    #1;
    clr_d2 = clr_d1;
    clr_d1 = s & c;
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.stb_in    = 1'b0;
    bus.phase_clr = 1'b0;
    clr_d1        = 1'b0;
    clr_d2        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    mphase = '0;
    mlfsr  = 16'hACE1;
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.stb_in = (i == 0);
      bus.audio  = 16'(i * 16'h1234 + 16'h0777);
      @(posedge clk);
      #1;
      checks++;
      if ({bus.stb_out, bus.xo, bus.yo, bus.zo} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: stb_out=%b xo=%0d yo=%0d zo=%06h, expected all 0",
                 bus.stb_out, bus.xo, bus.yo, bus.zo);
      end
    end
    bus.stb_in = 1'b0;
    rst        = 1'b0;
    mphase     = '0;
    mlfsr      = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.stb_out, bus.xo, bus.zo} !== '0) begin
        errors++;
        $display("FAIL post_reset_idle: stb_out=%b xo=%0d zo=%06h, expected all 0",
                 bus.stb_out, bus.xo, bus.zo);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_carrier_only();
    do_reset();
    bus.carrier_fw = 24'h100000;
    bus.dev_gain   = 16'h0000;
    repeat (4) step(1'b1, 16'h5555, 1'b0);
    drain();
  endtask

  task automatic test_deviation();
    do_reset();
    bus.carrier_fw = 24'h000000;
    bus.dev_gain   = 16'h0100;
    step(1'b1, 16'h4000, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'hC000, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.carrier_fw = 24'h700000;
    bus.dev_gain   = 16'h0000;
    repeat (3) step(1'b1, 16'h0000, 1'b0);
    drain();
  endtask

  task automatic test_phase_clr();
    do_reset();
    bus.carrier_fw = 24'h100000;
    bus.dev_gain   = 16'h0000;
    repeat (3) step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 1'b0);
    drain();
  endtask

  task automatic test_midstream_reset();
    int out0;
    do_reset();
    bus.carrier_fw = 24'h123456;
    bus.dev_gain   = 16'h0040;
    step(1'b1, 16'h1000, 1'b0);
    step(1'b1, 16'h2000, 1'b0);
    out0 = n_out;
    do_reset();
    drain();
    checks++;
    if (n_out !== out0) begin
      errors++;
      $display("FAIL midstream_reset: %0d outputs after reset, expected 0", n_out - out0);
    end
  endtask

  task automatic test_back_to_back_random();
    int in0;
    int out0;
    do_reset();
    bus.carrier_fw = 24'($urandom);
    bus.dev_gain   = 16'($urandom);
    in0  = n_in;
    out0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 16'($urandom), 1'b0);
      step(1'b1, 16'($urandom), 1'b0);
    end
    drain();
    checks++;
    if ((n_out - out0) !== (n_in - in0)) begin
      errors++;
      $display("FAIL random_count: got %0d outputs, expected %0d", n_out - out0, n_in - in0);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL random_pending: %0d expected outputs never seen, expected 0", sb.size());
    end
  endtask

  initial begin
    bus.audio      = '0;
    bus.stb_in     = 1'b0;
    bus.carrier_fw = '0;
    bus.dev_gain   = '0;
    bus.phase_clr  = 1'b0;
    test_reset();
    test_carrier_only();
    test_deviation();
    test_wrap();
    test_phase_clr();
    test_midstream_reset();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_phase_gen.md
Name: fm_phase_gen

Overview:
- FM modulator front end that sits directly upstream of the rotation-mode CORDIC.
- Per audio strobe, computes instantaneous frequency as carrier plus scaled audio, and accumulates it into a phase register.
- Folds the phase into the CORDIC convergence range of ±90°.
- Emits the xi/yi/zi/strobe set that the CORDIC consumes to produce the I/Q carrier.

Parameters:
- WIDTH, 16, width of x/y outputs; matches CORDIC WIDTH.
- ZWIDTH, 24, phase/angle width; matches CORDIC ZWIDTH. Angle scale: 2^(ZWIDTH-1) = π, two's complement.
- AWIDTH, 16, signed audio sample width.
- GWIDTH, 16, unsigned deviation gain width.
- DEV_SHIFT, 8, arithmetic right shift applied to the audio×gain product.
- AMPLITUDE, 19897, magnitude driven on xo; pre-compensates CORDIC gain 1.6468.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- audio  in  AWIDTH  signed audio sample; valid when stb_in=1.
- stb_in  in  1  sample strobe; any duty, back-to-back allowed.
- carrier_fw  in  ZWIDTH  carrier frequency word, phase increment per sample; quasi-static.
- dev_gain  in  GWIDTH  unsigned deviation gain; quasi-static.
- phase_clr  in  1  synchronous clear of phase accumulator.
- xo  out  WIDTH  to CORDIC xi; ±AMPLITUDE.
- yo  out  WIDTH  to CORDIC yi; always 0.
- zo  out  ZWIDTH  to CORDIC zi; folded angle.
- stb_out  out  1  output valid pulse, one cycle per input strobe.

Behaviour:
- Reset: all pipeline registers, the phase accumulator and all outputs go to 0 on the first clk edge with rst=1. stb_out=0, xo=yo=zo=0.
- Pipeline is 4 registered stages, each stage's valid bit tracks stb. Latency from stb_in to stb_out is exactly 4 cycles. No backpressure. Throughput is 1 sample/cycle.
- S1: prod = signed(audio) × unsigned(dev_gain). Full width AWIDTH+GWIDTH+1, registered.
- S2: dev = prod >>> DEV_SHIFT, then truncated or sign-extended to ZWIDTH. freq = carrier_fw + dev, mod 2^ZWIDTH with no saturation. Registered.
- S3: when the S3 valid bit is set, phase <= phase + freq, mod 2^ZWIDTH; wrap-around is silent. Otherwise phase holds.
- phase_clr: sets phase <= 0 on that edge and takes priority over a coinciding accumulate; that sample's increment is lost, but its valid bit still propagates. Samples in S1/S2 are unaffected and accumulate onto 0 afterwards. Samples already in S4 are unaffected.
- S4 fold uses q = phase[ZWIDTH-1:ZWIDTH-2]:
  - q=00 or 11: zo=phase, xo=+AMPLITUDE.
  - q=01 or 10: zo=phase with MSB inverted (i.e. −π), xo=−AMPLITUDE.
  - yo=0 always. S4 outputs are registered and updated only when the S4 valid bit is set; otherwise they hold.
- stb_out is high exactly one cycle per accepted stb_in, in order.
- rst mid-stream: all in-flight samples are discarded and no stb_out follows.

Optional Feature:
- Macro PHASE_DITHER_EN.
- With the macro: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 0xACE1) advances once per S4 valid. Its low 4 bits (zero-extended) are added to the phase before folding. Dither affects zo only; the phase accumulator is never dithered.
- Without the macro: no LFSR is instantiated, and zo is exactly as specified above.

Test Plan:
- rst asserted 2 cycles with stb_in toggling → xo=yo=zo=0, stb_out=0 throughout and for 4 cycles after release.
- carrier_fw=0x100000, dev_gain=0, four back-to-back strobes → stb_out on cycles 4–7. zo = 0x100000, 0x200000, 0x300000, 0xC00000. xo = +19897, +19897, +19897, −19897.
- carrier_fw=0, dev_gain=0x0100, audio=0x4000 then 0xC000, isolated strobes → phase 0x004000 then 0x000000. zo = 0x004000 then 0x000000, xo=+19897.
- carrier_fw=0x700000, 3 strobes → phase 0x700000, 0xE00000, 0x500000 (wrap). zo = 0xF00000, 0xE00000, 0xD00000. xo = −A, +A, −A.
- phase_clr coincident with a sample in S3 (carrier_fw=0x100000, after 3 prior samples) → that output zo=0x000000; the next sample gives zo=0x100000.
- stb_in with random gaps over 1000 samples → stb_out count equals stb_in count, each 4 cycles later. zo matches the reference model (±dither when PHASE_DITHER_EN is defined).
